// File: rtl/bram_port_decoder_pipe.sv
// Pipelined BRAM port A decoder: splits the word address into tag/index, drives registered
// write and read strobes, returns read data at a fixed latency and records unmapped accesses.
module bram_port_decoder_pipe #(
    parameter int                ADDR_W         = 22,
    parameter int                DATA_W         = 32,
    parameter int                TAG_W          = 3,
    parameter int                IDX_W          = 17,
    parameter int                ELEM_W         = 8,
    parameter int                NUM_WR         = 3,
    parameter int                NUM_RD         = 3,
    parameter int                WR_TAG_BASE    = 0,
    parameter int                RD_TAG_BASE    = 3,
    parameter int                RD_LAT         = 3,
    parameter logic [DATA_W-1:0] UNMAPPED_RDATA = DATA_W'(32'hDEAD_BEEF)
) (
    input  logic                     clk_a,
    input  logic                     rst_a,
    input  logic [ADDR_W-1:0]        addr_a,
    input  logic [DATA_W-1:0]        wrdata_a,
    output logic [DATA_W-1:0]        rddata_a,
    input  logic                     en_a,
    input  logic [DATA_W/8-1:0]      we_a,
    output logic [NUM_WR-1:0]        wr_en_o,
    output logic [IDX_W-1:0]         wr_addr_o,
    output logic [ELEM_W-1:0]        wr_data_o,
    output logic [NUM_RD-1:0]        rd_en_o,
    output logic [IDX_W-1:0]         rd_addr_o,
    input  logic [NUM_RD*ELEM_W-1:0] rd_data_i,
    input  logic                     err_clr_i,
    output logic                     err_sticky_o,
    output logic [15:0]              err_cnt_o,
    output logic [ADDR_W-1:0]        err_addr_o
);

    localparam int CH_W = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
    localparam int XTRA = RD_LAT - 3;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [DATA_W-1:0] zext_elem(input logic [ELEM_W-1:0] e);
        return DATA_W'(e);
    endfunction

    // p0: request classification and tag range decode
    logic [ADDR_W-3:0] waddr_p0;
    logic [TAG_W-1:0]  tag_p0;
    logic [IDX_W-1:0]  idx_p0;
    int                tag_i;
    int                wr_ch_i;
    int                rd_ch_i;
    logic              wr_req_p0;
    logic              rd_req_p0;
    logic              wr_hit_p0;
    logic              rd_hit_p0;
    logic              err_p0;

    assign waddr_p0 = addr_a[ADDR_W-1:2];
    assign tag_p0   = waddr_p0[ADDR_W-3 -: TAG_W];
    assign idx_p0   = waddr_p0[IDX_W-1:0];

    always_comb begin
        tag_i     = int'(tag_p0);
        wr_ch_i   = tag_i - WR_TAG_BASE;
        rd_ch_i   = tag_i - RD_TAG_BASE;
        wr_req_p0 = en_a & we_a[0];
        rd_req_p0 = en_a & ~we_a[0];
        wr_hit_p0 = wr_req_p0 && (wr_ch_i >= 0) && (wr_ch_i < NUM_WR);
        rd_hit_p0 = rd_req_p0 && (rd_ch_i >= 0) && (rd_ch_i < NUM_RD);
        err_p0    = (wr_req_p0 && !wr_hit_p0) || (rd_req_p0 && !rd_hit_p0);
    end

    // p1: registered strobes, shared index/data and error capture
    always_ff @(posedge clk_a) begin
        if (rst_a) begin
            wr_en_o   <= '0;
            wr_addr_o <= '0;
            wr_data_o <= '0;
            rd_en_o   <= '0;
            rd_addr_o <= '0;
        end else begin
            wr_en_o <= '0;
            rd_en_o <= '0;
            if (wr_hit_p0) begin
                wr_en_o   <= NUM_WR'(1) << wr_ch_i;
                wr_addr_o <= idx_p0;
                wr_data_o <= wrdata_a[ELEM_W-1:0];
            end
            if (rd_hit_p0) begin
                rd_en_o   <= NUM_RD'(1) << rd_ch_i;
                rd_addr_o <= idx_p0;
            end
        end
    end

    // A new error in the same cycle as a clear restarts the count at one.
    always_ff @(posedge clk_a) begin
        if (rst_a) begin
            err_sticky_o <= 1'b0;
            err_cnt_o    <= '0;
            err_addr_o   <= '0;
        end else if (err_p0) begin
            err_sticky_o <= 1'b1;
            err_cnt_o    <= err_clr_i ? 16'd1 : sat_inc(err_cnt_o);
            err_addr_o   <= addr_a;
        end else if (err_clr_i) begin
            err_sticky_o <= 1'b0;
            err_cnt_o    <= '0;
        end
    end

    logic            vld_p1;
    logic            vld_p2;
    logic            um_p1;
    logic            um_p2;
    logic [CH_W-1:0] ch_p1;
    logic [CH_W-1:0] ch_p2;

    always_ff @(posedge clk_a) begin
        if (rst_a) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            vld_p1 <= rd_req_p0;
            vld_p2 <= vld_p1;
        end
    end

    always_ff @(posedge clk_a) begin
        um_p1 <= ~rd_hit_p0;
        ch_p1 <= CH_W'(rd_ch_i);
        um_p2 <= um_p1;
        ch_p2 <= ch_p1;
    end

    // p2: buffer data is on rd_data_i; select the slice of the issuing channel
    logic              res_vld_p2;
    logic [DATA_W-1:0] res_data_p2;
    logic              fin_vld;
    logic [DATA_W-1:0] fin_data;

    assign res_vld_p2  = vld_p2;
    assign res_data_p2 = um_p2 ? UNMAPPED_RDATA
                               : zext_elem(rd_data_i[int'(ch_p2)*ELEM_W +: ELEM_W]);

    generate
        if (XTRA == 0) begin : g_no_dly
            assign fin_vld  = res_vld_p2;
            assign fin_data = res_data_p2;
        end else begin : g_dly
            logic [XTRA-1:0]   dly_vld;
            logic [DATA_W-1:0] dly_data [XTRA];

            always_ff @(posedge clk_a) begin
                if (rst_a) begin
                    dly_vld <= '0;
                end else begin
                    dly_vld[0] <= res_vld_p2;
                    for (int i = 1; i < XTRA; i++) dly_vld[i] <= dly_vld[i-1];
                end
            end

            always_ff @(posedge clk_a) begin
                dly_data[0] <= res_data_p2;
                for (int i = 1; i < XTRA; i++) dly_data[i] <= dly_data[i-1];
            end

            assign fin_vld  = dly_vld[XTRA-1];
            assign fin_data = dly_data[XTRA-1];
        end
    endgenerate

    // Output hold register: only a completed read changes rddata_a.
    always_ff @(posedge clk_a) begin
        if (rst_a) begin
            rddata_a <= '0;
        end else if (fin_vld) begin
            rddata_a <= fin_data;
        end
    end

    logic unused_inputs;
    assign unused_inputs = ^{we_a, wrdata_a, addr_a};

endmodule

// File: doc/bram_port_decoder_pipe.md
Name: bram_port_decoder_pipe

Overview:
- Parametrised, pipelined successor to the combinational BRAM-port address decoder.
- Sits between the AXI BRAM controller port (port A) and the accelerator's on-chip buffers: SA BRAM, FC weight/ifmap buffers and result/pool buffers.
- Decodes a word-address tag into NUM_WR write channels and NUM_RD read channels, and registers all outputs.
- Aligns returned read data to a fixed read latency RD_LAT, and counts and captures accesses to unmapped tags.

Parameters:
ADDR_W, 22, byte address width of addr_a
DATA_W, 32, width of wrdata_a/rddata_a
TAG_W, 3, tag width: the top TAG_W bits of the word address (addr_a[ADDR_W-1:2])
IDX_W, 17, buffer index width: the low IDX_W bits of the word address; requires IDX_W+TAG_W <= ADDR_W-2
ELEM_W, 8, element width written to and read from the buffers; requires ELEM_W <= 8
NUM_WR, 3, number of write channels, tags WR_TAG_BASE .. WR_TAG_BASE+NUM_WR-1
NUM_RD, 3, number of read channels, tags RD_TAG_BASE .. RD_TAG_BASE+NUM_RD-1; write and read tag ranges must not overlap
WR_TAG_BASE, 0, first write tag
RD_TAG_BASE, 3, first read tag
RD_LAT, 3, cycles from read request to valid rddata_a; requires RD_LAT >= 3
UNMAPPED_RDATA, 32'hDEAD_BEEF, value returned for a read of an unmapped tag

Ports:
clk_a  in  1  clock
rst_a  in  1  synchronous, active-high reset
addr_a  in  ADDR_W  byte address from the BRAM controller
wrdata_a  in  DATA_W  write data
rddata_a  out  DATA_W  read data, valid RD_LAT cycles after the request
en_a  in  1  port enable
we_a  in  DATA_W/8  byte write enables
wr_en_o  out  NUM_WR  one-hot write strobe, bit k = channel k
wr_addr_o  out  IDX_W  write index, shared by all write channels
wr_data_o  out  ELEM_W  write data, shared by all write channels
rd_en_o  out  NUM_RD  one-hot read strobe
rd_addr_o  out  IDX_W  read index, shared by all read channels
rd_data_i  in  NUM_RD*ELEM_W  flattened read data; channel k occupies [k*ELEM_W +: ELEM_W]; 1-cycle buffer latency
err_clr_i  in  1  clears the error counter and sticky flag
err_sticky_o  out  1  set on any unmapped access
err_cnt_o  out  16  saturating count of unmapped accesses
err_addr_o  out  ADDR_W  byte address of the most recent unmapped access

Behaviour:
- Request classification, decided in cycle T:
  - write request = en_a & we_a[0]
  - read request = en_a & ~we_a[0]
  - we_a[3:1] are ignored
  - waddr = addr_a[ADDR_W-1:2]; tag = waddr[ADDR_W-3 -: TAG_W]; idx = waddr[IDX_W-1:0]
- Write path:
  - A write hitting channel k drives, at T+1 for exactly one cycle: wr_en_o = 1<<k, wr_addr_o = idx, wr_data_o = wrdata_a[ELEM_W-1:0].
  - Otherwise wr_en_o = 0 and wr_addr_o/wr_data_o hold their last values.
  - A write to a read tag is unmapped.
- Read path:
  - A read hitting channel k drives rd_en_o = 1<<k and rd_addr_o = idx at T+1.
  - The buffer returns data on rd_data_i at T+2; the decoder registers the selected slice, zero-extended, into a hold register at T+3.
  - For RD_LAT > 3, (RD_LAT-3) further register stages are added.
  - rddata_a is updated at T+RD_LAT and holds until the next read result; it does not change on writes or idle cycles.
  - A read to an unmapped tag or a write tag issues no rd_en_o, and returns UNMAPPED_RDATA at T+RD_LAT.
- Pipeline and throughput:
  - Channel select and valid travel through an RD_LAT-deep shift register alongside the data.
  - One request per cycle is sustained; back-to-back reads, and reads interleaved with writes, complete in order with no bubbles.
- Error logic, for an unmapped access (enabled, and the tag is in neither valid range for its direction):
  - err_sticky_o is set at T+1.
  - err_cnt_o increments at T+1, saturating at 16'hFFFF.
  - err_addr_o captures addr_a at T+1.
  - err_clr_i clears the counter and sticky flag at the next edge; err_addr_o is not cleared.
  - err_clr_i and a new error in the same cycle: the error wins, giving err_cnt_o = 1 and err_sticky_o = 1.
- Reset (rst_a=1 at an edge):
  - All outputs go to 0, including rddata_a and err_addr_o.
  - The pipeline valid bits are cleared, so in-flight reads are dropped and produce no update after reset.
  - Requests presented while rst_a=1 are ignored.
- en_a=0: no strobes and no error, whatever we_a and addr_a are.

Test Plan:
- Single write, tag=1, idx=0x00123, wrdata_a=0x000000A5, we_a=4'hF -> at T+1 wr_en_o=3'b010, wr_addr_o=0x00123, wr_data_o=0xA5, asserted for one cycle only.
- Read, tag=4 (channel 1), idx=0x2F, with the bench returning rd_data_i[15:8]=0x3C at T+2 -> rd_en_o=3'b010 and rd_addr_o=0x2F at T+1; rddata_a=0x0000003C at T+3 and held.
- Four back-to-back reads to channels 0,1,2,0 returning 0x11,0x22,0x33,0x44 -> rddata_a shows 0x11,0x22,0x33,0x44 on consecutive cycles starting at T+3.
- Read of tag=7 at addr 0x3C0010 -> no rd_en_o; rddata_a=0xDEADBEEF at T+3; err_cnt_o=1, err_sticky_o=1, err_addr_o=0x3C0010.
- Write to tag=5 with err_clr_i asserted in the same cycle, and err_cnt_o previously 3 -> err_cnt_o=1, err_sticky_o=1, wr_en_o=0.
- Read issued, then rst_a asserted at T+1 for one cycle -> rddata_a=0 from reset and remains 0 at T+3; error counter reads 0.
